// File: rtl/bit_deser.sv
// Serial-to-parallel deserializer: assembles WIDTH-bit words from a gated bit stream
// and presents them through a 2-entry valid/ready queue with sticky overflow reporting.
module bit_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [15:0]      word_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] q0_q, q0_d, q1_q, q1_d;
  logic [1:0]       qcnt_q, qcnt_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      word_cnt_q, word_cnt_d;

  logic [WIDTH-1:0] shifted, fresh;
  logic             push, pop, drop;

  // Bit assembly; sync restarts alignment and never pushes a word.
  always_comb begin
    shifted = MSB_FIRST ? {shift_q[WIDTH-2:0], din} : {din, shift_q[WIDTH-1:1]};
    fresh   = MSB_FIRST ? {{(WIDTH-1){1'b0}}, din} : {din, {(WIDTH-1){1'b0}}};
    cnt_d   = cnt_q;
    shift_d = shift_q;
    push    = 1'b0;
    if (sync) begin
      cnt_d   = din_vld ? CW'(1) : '0;
      shift_d = din_vld ? fresh : '0;
    end else if (din_vld) begin
      shift_d = shifted;
      if (cnt_q == LAST) begin
        push  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Output queue: q0 is always the head; a push into a full queue without a pop is dropped.
  always_comb begin
    q0_d   = q0_q;
    q1_d   = q1_q;
    qcnt_d = qcnt_q;
    drop   = 1'b0;
    pop    = (qcnt_q != 2'd0) && dout_rdy;
    case (qcnt_q)
      2'd0: begin
        if (push) begin
          q0_d   = shifted;
          qcnt_d = 2'd1;
        end
      end
      2'd1: begin
        case ({push, pop})
          2'b10: begin
            q1_d   = shifted;
            qcnt_d = 2'd2;
          end
          2'b01: qcnt_d = 2'd0;
          2'b11: q0_d = shifted;
          default: ;
        endcase
      end
      default: begin
        if (pop) begin
          q0_d = q1_q;
          if (push) q1_d = shifted;
          else      qcnt_d = 2'd1;
        end else if (push) begin
          drop = 1'b1;
        end
      end
    endcase
    ovf_d      = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    word_cnt_d = word_cnt_q + {15'd0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      shift_q    <= '0;
      q0_q       <= '0;
      q1_q       <= '0;
      qcnt_q     <= 2'd0;
      ovf_q      <= 1'b0;
      word_cnt_q <= 16'd0;
    end else begin
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      q0_q       <= q0_d;
      q1_q       <= q1_d;
      qcnt_q     <= qcnt_d;
      ovf_q      <= ovf_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign dout     = q0_q;
  assign dout_vld = (qcnt_q != 2'd0);
  assign ovf      = ovf_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_bit_deser.sv
// Self-checking bench for bit_deser: MSB-first and LSB-first instances share one stimulus
// stream and are compared each cycle against a queue-based reference model.
module tb_bit_deser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, din, din_vld, sync, dout_rdy, ovf_clr;
  logic [7:0]  dout_m, dout_l;
  logic        vld_m, vld_l, ovf_m, ovf_l;
  logic [15:0] wc_m, wc_l;

  int tests = 0;
  int fails = 0;

  int          bitq[$];
  logic [7:0]  expq_m[$];
  logic [7:0]  expq_l[$];
  logic        ovf_e;
  logic [15:0] wc_e;

  bit_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .sync(sync),
    .dout(dout_m), .dout_vld(vld_m), .dout_rdy(dout_rdy),
    .ovf(ovf_m), .ovf_clr(ovf_clr), .word_cnt(wc_m)
  );

  bit_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .sync(sync),
    .dout(dout_l), .dout_vld(vld_l), .dout_rdy(dout_rdy),
    .ovf(ovf_l), .ovf_clr(ovf_clr), .word_cnt(wc_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: collects bits until 8 arrive, then builds both bit orders arithmetically.
  task automatic model_step();
    logic       popped, pushed;
    logic [7:0] wm, wl;
    popped = 1'b0;
    pushed = 1'b0;
    wm = 8'd0;
    wl = 8'd0;
    if (rst) begin
      bitq.delete();
      expq_m.delete();
      expq_l.delete();
      ovf_e = 1'b0;
      wc_e  = 16'd0;
    end else begin
      popped = (expq_m.size() > 0) && dout_rdy;
      if (sync) begin
        bitq.delete();
        if (din_vld) bitq.push_back(int'(din));
      end else if (din_vld) begin
        bitq.push_back(int'(din));
        if (bitq.size() == 8) begin
          pushed = 1'b1;
          for (int i = 0; i < 8; i++) begin
            wm = wm + 8'(bitq[i] << (7 - i));
            wl = wl + 8'(bitq[i] << i);
          end
          bitq.delete();
        end
      end
      if (popped) begin
        void'(expq_m.pop_front());
        void'(expq_l.pop_front());
        wc_e = wc_e + 16'd1;
      end
      if (pushed && expq_m.size() < 2) begin
        expq_m.push_back(wm);
        expq_l.push_back(wl);
      end else if (pushed) begin
        ovf_e = 1'b1;
      end else if (ovf_clr) begin
        ovf_e = 1'b0;
      end
      if (pushed && expq_m.size() == 2 && !popped && ovf_clr) ovf_e = ovf_e;
    end
  endtask

  task automatic checkOutputs();
    chk("vld_msb", vld_m, expq_m.size() > 0);
    chk("vld_lsb", vld_l, expq_l.size() > 0);
    if (expq_m.size() > 0) chk("dout_msb", dout_m, expq_m[0]);
    if (expq_l.size() > 0) chk("dout_lsb", dout_l, expq_l[0]);
    chk("ovf_msb", ovf_m, ovf_e);
    chk("ovf_lsb", ovf_l, ovf_e);
    chk("wcnt_msb", wc_m, wc_e);
    chk("wcnt_lsb", wc_l, wc_e);
  endtask

  task automatic tick(input logic d, input logic v, input logic s, input logic r, input logic c);
    din      = d;
    din_vld  = v;
    sync     = s;
    dout_rdy = r;
    ovf_clr  = c;
    @(posedge clk);
    model_step();
    #1;
    checkOutputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    chk("rst_dout_msb", dout_m, 8'h00);
    chk("rst_dout_lsb", dout_l, 8'h00);
  endtask

  task automatic send_word(input logic [7:0] w, input int gap, input logic r);
    for (int i = 7; i >= 0; i--) begin
      tick(w[i], 1'b1, 1'b0, r, 1'b0);
      if (i > 0) repeat (gap) tick(1'b0, 1'b0, 1'b0, r, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] w;
    rst = 1'b1; din = 1'b0; din_vld = 1'b0; sync = 1'b0; dout_rdy = 1'b0; ovf_clr = 1'b0;
    wc_e = 16'd0; ovf_e = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // 0xA5 back-to-back with a ready consumer: one-cycle dout_vld pulse.
    send_word(8'hA5, 0, 1'b1);
    chk("a5_vld", vld_m, 1'b1);
    chk("a5_dout", dout_m, 8'hA5);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("a5_pulse", vld_m, 1'b0);
    chk("a5_cnt", wc_m, 16'd1);

    // First bit set, rest clear: lands at opposite ends for the two bit orders.
    send_word(8'h80, 0, 1'b1);
    chk("msb_first", dout_m, 8'h80);
    chk("lsb_first", dout_l, 8'h01);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Gapped din_vld, one valid bit every third cycle.
    send_word(8'h3C, 2, 1'b1);
    chk("gap_dout", dout_m, 8'h3C);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overflow: stalled consumer, three words back-to-back.
    do_reset();
    send_word(8'h11, 0, 1'b0);
    send_word(8'h22, 0, 1'b0);
    send_word(8'h33, 0, 1'b0);
    chk("ovf_set", ovf_m, 1'b1);
    chk("ovf_head", dout_m, 8'h11);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_second", dout_m, 8'h22);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_drained", vld_m, 1'b0);
    chk("ovf_cnt", wc_m, 16'd2);
    chk("ovf_sticky", ovf_m, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", ovf_m, 1'b0);

    // sync after 5 bits realigns: the sync-cycle bit starts 0xC3.
    w = 8'hC3;
    repeat (5) tick(1'($urandom % 2), 1'b1, 1'b0, 1'b1, 1'b0);
    tick(w[7], 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 6; i >= 0; i--) tick(w[i], 1'b1, 1'b0, 1'b1, 1'b0);
    chk("sync_vld", vld_m, 1'b1);
    chk("sync_dout", dout_m, 8'hC3);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset with a queued word and a partial word in flight.
    send_word(8'h77, 0, 1'b0);
    w = 8'h5A;
    for (int i = 7; i >= 4; i--) tick(w[i], 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    chk("rst_vld", vld_m, 1'b0);
    chk("rst_cnt", wc_m, 16'd0);
    send_word(8'h5A, 0, 1'b1);
    chk("fresh_dout", dout_m, 8'h5A);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fresh_cnt", wc_m, 16'd1);

    // Randomized traffic including occasional sync, clear and reset.
    repeat (600) begin
      rst = ($urandom_range(0, 99) == 0);
      tick(1'($urandom % 2), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
           1'($urandom % 2), ($urandom_range(0, 19) == 0));
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
